hub75_framebuf: RTL and testbench
=================================

Name: hub75_framebuf

Overview:
Double-buffered frame memory that sits directly upstream of the HUB75 scan/display engine. It accepts a raster-ordered pixel stream from the host or pattern generator into a back buffer. It serves the display engine's segment-parallel RGB reads from the front buffer. Front and back buffers swap only at a display frame boundary, so a partially written frame is never shown.

Parameters:
hpixel_p, 64, display width in pixels
vpixel_p, 64, display height in pixels
bpp_p, 8, bits per colour channel
segments_p, 2, number of display segments; vpixel_p must divide evenly by segments_p
frame_size_p (localparam), hpixel_p*vpixel_p, pixels per frame
seg_size_p (localparam), frame_size_p/segments_p, pixels per segment bank
addr_width_p (localparam), $clog2(frame_size_p), address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_wr_valid  in  1  write pixel valid
o_wr_ready  out  1  write pixel accepted when high with valid
i_wr_sof  in  1  qualifies the beat as first pixel of a frame
i_wr_eof  in  1  qualifies the beat as last pixel of a frame
i_wr_data  in  [2:0][bpp_p-1:0]  pixel; [0]=R, [1]=G, [2]=B
i_rd_addr  in  addr_width_p  segment-local read address from display engine
o_rd_data  out  [segments_p-1:0][2:0][bpp_p-1:0]  pixel per segment
i_frame_done  in  1  single-cycle pulse from display engine at end of a full scan
o_front_sel  out  1  index of buffer currently displayed
o_swap  out  1  single-cycle pulse on the cycle after a swap takes effect
o_wr_ptr  out  addr_width_p  next write linear pixel index (status)

Behaviour:
- Reset (async assert, sync release): o_front_sel=0, o_swap=0, o_wr_ptr=0, swap_pending=0, o_rd_data=0, o_wr_ready=1. Memory contents undefined.
- Storage: 2 buffers x segments_p banks, each seg_size_p words of 3*bpp_p bits.
- Write mapping: linear index p (row-major, p=y*hpixel_p+x). Bank = p/seg_size_p, local address = p%seg_size_p, buffer = ~o_front_sel.
- Accept = i_wr_valid & o_wr_ready.
- On accept with i_wr_sof=1, the pixel is written at p=0 and o_wr_ptr becomes 1. This holds regardless of the current pointer: a mid-frame sof restarts the frame.
- On accept without sof, the pixel is written at p=o_wr_ptr and o_wr_ptr increments.
- Frame completion: an accept with i_wr_eof=1, or an accept at p=frame_size_p-1, sets swap_pending=1 and o_wr_ptr=0.
- eof before the last pixel leaves the remaining back-buffer pixels stale.
- o_wr_ready = ~swap_pending (combinational from the register). No writes are accepted while a completed frame awaits its swap.
- Swap: on a cycle with i_frame_done=1 and swap_pending=1, next cycle o_front_sel toggles, swap_pending=0 and o_swap=1 for one cycle.
- i_frame_done with swap_pending=0 has no effect, and the same frame is shown again.
- Simultaneous completion and i_frame_done: the frame_done sees the registered swap_pending (0), so no swap happens. The swap occurs at the next i_frame_done.
- Read: registered with 1-cycle latency. o_rd_data[s] = front buffer, bank s, word i_rd_addr, sampled from i_rd_addr on the previous edge.
- If i_rd_addr >= seg_size_p, o_rd_data is all zeros (blank) on that return cycle.
- The read buffer select is taken from o_front_sel at the address cycle. The read issued on the swap edge already uses the new front buffer.
- Reads and writes never target the same buffer, so there is no read/write collision.
- Reset mid-frame: the pointer returns to 0, the pending swap is lost, and front returns to buffer 0.

Test Plan:
1. Reset, then stream 4096 pixels with value p[7:0] in every channel, sof on the first beat and eof on the last. Expect o_wr_ready=0 after the last beat. Pulse i_frame_done; o_swap=1 next cycle and o_front_sel=1. Read addr 5 -> seg0 data 0x05, seg1 data (2048+5)[7:0]=0x05, both one cycle later.
2. Write a frame of all 0xFF and pulse i_frame_done before eof. Expect no swap, and reads still return frame 1 data. After eof and the next i_frame_done, a swap occurs and reads return 0xFF.
3. eof on the last beat in the same cycle as i_frame_done -> no swap that cycle, o_wr_ready=0. The next i_frame_done swaps.
4. sof asserted at p=100 with data 0xAA -> o_wr_ptr=1, and after completion word 0 reads 0xAA.
5. Read i_rd_addr=2048 (>= seg_size_p) -> o_rd_data=0 on the following cycle.
6. Assert rst_n=0 mid-stream at p=300 -> outputs return to reset values immediately. A following sof restarts cleanly at p=0.

Source files
------------

// File: rtl/hub75_framebuf.sv
`default_nettype none
// ============================================================================
// Module   : hub75_framebuf
// Brief    : Double-buffered, segment-banked frame memory feeding the HUB75
//            scan engine. Raster pixels fill the back buffer. The display
//            engine reads one pixel per segment from the front buffer.
//            Buffers swap only on a display frame boundary.
// Revision : 1.0  initial release
// ============================================================================
module hub75_framebuf #(
  parameter int hpixel_p    = 64,
  parameter int vpixel_p    = 64,
  parameter int bpp_p       = 8,
  parameter int segments_p  = 2,
  localparam int frame_size_p = hpixel_p * vpixel_p,
  localparam int seg_size_p   = frame_size_p / segments_p,
  localparam int addr_width_p = $clog2(frame_size_p)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_wr_valid,
  output logic                                     o_wr_ready,
  input  logic                                     i_wr_sof,
  input  logic                                     i_wr_eof,
  input  logic [2:0][bpp_p-1:0]                    i_wr_data,
  input  logic [addr_width_p-1:0]                  i_rd_addr,
  output logic [segments_p-1:0][2:0][bpp_p-1:0]    o_rd_data,
  input  logic                                     i_frame_done,
  output logic                                     o_front_sel,
  output logic                                     o_swap,
  output logic [addr_width_p-1:0]                  o_wr_ptr
);

  // Bank-local address width; at least one bit so the slices stay legal.
  localparam int seg_aw_p  = (seg_size_p > 1) ? $clog2(seg_size_p) : 1;
  localparam int word_w_p  = 3 * bpp_p;

  // One extra bit so a single-segment bank size (== frame size) still fits.
  localparam logic [addr_width_p:0]   seg_size_c = (addr_width_p + 1)'(seg_size_p);
  localparam logic [addr_width_p-1:0] last_idx_c = addr_width_p'(frame_size_p - 1);

  logic                     swap_pending;
  logic                     accept;
  logic [addr_width_p-1:0]  wr_idx;
  logic                     wr_last;
  logic                     swap_take;
  logic                     front_next;
  logic [addr_width_p:0]    wr_bank;
  logic [seg_aw_p-1:0]      wr_local;
  logic                     rd_in_range;

  // A completed frame blocks further writes until it has been swapped in.
  assign o_wr_ready = ~swap_pending;

  // Write indexing, frame completion and swap qualification.
  always_comb begin
    accept      = i_wr_valid & ~swap_pending;
    wr_idx      = i_wr_sof ? '0 : o_wr_ptr;
    wr_last     = i_wr_eof | (wr_idx == last_idx_c);
    swap_take   = i_frame_done & swap_pending;
    // Reads launched on the swap edge must already see the new front buffer.
    front_next  = o_front_sel ^ swap_take;
    wr_bank     = {1'b0, wr_idx} / seg_size_c;
    wr_local    = seg_aw_p'({1'b0, wr_idx} % seg_size_c);
    rd_in_range = ({1'b0, i_rd_addr} < seg_size_c);
  end

  // Write pointer, pending-swap flag, front-buffer select and swap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_front_sel  <= 1'b0;
      o_swap       <= 1'b0;
      o_wr_ptr     <= '0;
      swap_pending <= 1'b0;
    end else begin
      o_swap <= swap_take;
      if (swap_take) begin
        o_front_sel  <= ~o_front_sel;
        swap_pending <= 1'b0;
      end
      // accept implies swap_pending==0, so this never collides with the swap.
      if (accept) begin
        if (wr_last) begin
          swap_pending <= 1'b1;
          o_wr_ptr     <= '0;
        end else begin
          o_wr_ptr     <= wr_idx + 1'b1;
        end
      end
    end
  end

  genvar s;
  generate
    for (s = 0; s < segments_p; s++) begin : g_bank
      logic [word_w_p-1:0] mem [2][seg_size_p];
      logic [word_w_p-1:0] rd_q;
      logic                wr_en;

      assign wr_en = accept & (wr_bank == (addr_width_p + 1)'(s));

      // Back-buffer write port for this segment bank.
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[~o_front_sel][wr_local] <= i_wr_data;
        end
      end

      // Front-buffer registered read; out-of-range addresses return blank.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else if (rd_in_range) begin
          rd_q <= mem[front_next][i_rd_addr[seg_aw_p-1:0]];
        end else begin
          rd_q <= '0;
        end
      end

      assign o_rd_data[s] = rd_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hub75_framebuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_framebuf
// Brief    : Self-checking bench for hub75_framebuf. A linear-frame model of
//            the two buffers predicts every output each cycle; directed
//            tests pin the model with literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_hub75_framebuf;

  localparam int FS  = 4096;
  localparam int SEG = 2048;

  logic             clk;
  logic             rst_n;
  logic             wr_valid;
  logic             wr_ready;
  logic             wr_sof;
  logic             wr_eof;
  logic [2:0][7:0]  wr_data;
  logic [11:0]      rd_addr;
  logic [1:0][2:0][7:0] rd_data;
  logic             frame_done;
  logic             front_sel;
  logic             swap;
  logic [11:0]      wr_ptr;

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  hub75_framebuf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_sof     (wr_sof),
    .i_wr_eof     (wr_eof),
    .i_wr_data    (wr_data),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .i_frame_done (frame_done),
    .o_front_sel  (front_sel),
    .o_swap       (swap),
    .o_wr_ptr     (wr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: two linear frames ----------------
  logic [23:0] mem_m   [2][FS];
  bit          valid_m [2][FS];
  logic        m_front, m_pend, m_swap;
  int          m_ptr;
  logic [1:0][23:0] m_rd;
  logic [1:0]  m_rd_known;
  logic        m_acc, m_nf;
  int          m_p;

  always_comb begin
    m_acc = wr_valid && !m_pend;
    m_nf  = m_front ^ (frame_done && m_pend);
    m_p   = wr_sof ? 0 : m_ptr;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_front    <= 1'b0;
      m_pend     <= 1'b0;
      m_swap     <= 1'b0;
      m_ptr      <= 0;
      m_rd       <= '0;
      m_rd_known <= 2'b11;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < FS; i++)
          valid_m[b][i] <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (int'(rd_addr) >= SEG) begin
          m_rd[s]       <= '0;
          m_rd_known[s] <= 1'b1;
        end else begin
          m_rd[s]       <= mem_m[m_nf][s*SEG + int'(rd_addr)];
          m_rd_known[s] <= valid_m[m_nf][s*SEG + int'(rd_addr)];
        end
      end
      m_swap <= frame_done && m_pend;
      if (frame_done && m_pend) begin
        m_front <= ~m_front;
        m_pend  <= 1'b0;
      end
      if (m_acc) begin
        mem_m[~m_front][m_p]   <= wr_data;
        valid_m[~m_front][m_p] <= 1'b1;
        if (wr_eof || m_p == FS-1) begin
          m_pend <= 1'b1;
          m_ptr  <= 0;
        end else begin
          m_ptr  <= m_p + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",  64'(wr_ready),  64'(!m_pend));
      chk("front",  64'(front_sel), 64'(m_front));
      chk("swap",   64'(swap),      64'(m_swap));
      chk("wr_ptr", 64'(wr_ptr),    64'(m_ptr));
      for (int s = 0; s < 2; s++)
        if (m_rd_known[s])
          chk("rd_data", 64'(rd_data[s]), 64'(m_rd[s]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [23:0] d, input logic s, input logic e, input logic f);
    wr_valid   = 1'b1;
    wr_data    = d;
    wr_sof     = s;
    wr_eof     = e;
    frame_done = f;
    step();
    wr_valid   = 1'b0;
    wr_sof     = 1'b0;
    wr_eof     = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_sof     = 1'b0;
    wr_eof     = 1'b0;
    wr_data    = '0;
    rd_addr    = '0;
    frame_done = 1'b0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_front", 64'(front_sel), 64'd0);
    chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: full frame with p[7:0] in every channel, then swap and read.
    for (int p = 0; p < FS; p++)
      beat({3{p[7:0]}}, p == 0, p == FS-1, 1'b0);
    chk("t1_ready_low", 64'(wr_ready), 64'd0);
    pulse_fd();
    chk("t1_swap", 64'(swap), 64'd1);
    chk("t1_front", 64'(front_sel), 64'd1);
    rd_addr = 12'd5;
    step();
    chk("t1_seg0", 64'(rd_data[0]), 64'h050505);
    chk("t1_seg1", 64'(rd_data[1]), 64'h050505);
    chk("t1_swap_single", 64'(swap), 64'd0);

    // 2: frame_done mid-frame has no effect; swap after eof.
    for (int p = 0; p < FS; p++) begin
      beat(24'hFFFFFF, p == 0, p == FS-1, p == 1000);
      if (p == 1000) begin
        chk("t2_no_swap", 64'(swap), 64'd0);
        chk("t2_front_kept", 64'(front_sel), 64'd1);
      end
    end
    chk("t2_old_data", 64'(rd_data[0]), 64'h050505);
    pulse_fd();
    chk("t2_front", 64'(front_sel), 64'd0);
    chk("t2_new_seg0", 64'(rd_data[0]), 64'hFFFFFF);
    chk("t2_new_seg1", 64'(rd_data[1]), 64'hFFFFFF);

    // 3: eof coincident with frame_done -> swap waits for the next one.
    for (int p = 0; p < FS; p++)
      beat({3{8'(p + 1)}}, p == 0, p == FS-1, p == FS-1);
    chk("t3_no_swap", 64'(swap), 64'd0);
    chk("t3_ready_low", 64'(wr_ready), 64'd0);
    step();
    chk("t3_front_kept", 64'(front_sel), 64'd0);
    pulse_fd();
    chk("t3_swap", 64'(swap), 64'd1);
    chk("t3_front", 64'(front_sel), 64'd1);
    chk("t3_seg0", 64'(rd_data[0]), 64'h060606);

    // 4: mid-frame sof restarts the frame at p=0.
    for (int p = 0; p < 100; p++)
      beat(24'h111111, p == 0, 1'b0, 1'b0);
    beat(24'hAAAAAA, 1'b1, 1'b0, 1'b0);
    chk("t4_ptr_restart", 64'(wr_ptr), 64'd1);
    for (int i = 1; i < FS; i++)
      beat(24'h222222, 1'b0, i == FS-1, 1'b0);
    chk("t4_ready_low", 64'(wr_ready), 64'd0);
    pulse_fd();
    rd_addr = 12'd0;
    step();
    chk("t4_word0", 64'(rd_data[0]), 64'hAAAAAA);
    chk("t4_seg1", 64'(rd_data[1]), 64'h222222);

    // 5: out-of-range read address returns blank.
    rd_addr = 12'd2048;
    step();
    chk("t5_blank", 64'(rd_data), 64'd0);
    rd_addr = 12'd0;

    // 6: asynchronous reset mid-stream, then clean restart.
    for (int p = 0; p < 300; p++)
      beat(24'h333333, p == 0, 1'b0, 1'b0);
    chk("t6_ptr_before", 64'(wr_ptr), 64'd300);
    chk("t6_rd_before", 64'(rd_data[0]), 64'hAAAAAA);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ptr", 64'(wr_ptr), 64'd0);
    chk("t6_rst_ready", 64'(wr_ready), 64'd1);
    chk("t6_rst_front", 64'(front_sel), 64'd0);
    chk("t6_rst_swap", 64'(swap), 64'd0);
    chk("t6_rst_rd", 64'(rd_data), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    beat(24'h444444, 1'b1, 1'b0, 1'b0);
    chk("t6_restart_ptr", 64'(wr_ptr), 64'd1);
    for (int i = 0; i < 3; i++)
      beat(24'h444444, 1'b0, 1'b0, 1'b0);
    chk("t6_ptr_4", 64'(wr_ptr), 64'd4);
    step();
    chk_en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
